// File: rtl/ahbl_regfile_slave.sv
// AHB-Lite register-file slave: NUM_REGS RW words plus a read-only ID word.
// Define AHBL_REGFILE_ERR_EN to build the two-cycle ERROR response path.
module ahbl_regfile_slave #(
    parameter logic [31:0] ID          = 32'hABCD_EF00,
    parameter int          NUM_REGS    = 4,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter int          ADDR_W      = 12
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HREADY,
    input  logic [2:0]               HSIZE,
    input  logic                     HWRITE,
    input  logic [31:0]              HWDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [31:0]              HRDATA,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_stb
);

    localparam int             IW      = ADDR_W - 2;
    localparam logic [IW-1:0]  ID_IDX  = IW'(NUM_REGS);
    localparam logic [2:0]     WS_LOAD = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

`ifdef AHBL_REGFILE_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

    state_t                      r_state;
    state_t                      w_next;
    logic [IW-1:0]               r_idx;
    logic [1:0]                  r_lo;
    logic [2:0]                  r_size;
    logic                        r_write;
    logic                        r_bad;
    logic [2:0]                  r_cnt;
    logic [NUM_REGS-1:0][31:0]   r_regs;
    logic [NUM_REGS-1:0]         r_stb;

    logic                        w_cap;
    logic                        w_load;
    logic [IW-1:0]               w_aidx;
    logic                        w_abad;
    logic                        w_commit;
    logic [3:0]                  w_be;
    logic                        w_unused;

    assign w_cap    = HREADY & HSEL & HTRANS[1];
    assign w_aidx   = HADDR[ADDR_W-1:2];
    assign w_abad   = (w_aidx > ID_IDX) | (HSIZE > 3'd2);
    assign w_commit = (r_state == S_DATA) & r_write & ~r_bad & (r_idx != ID_IDX);
    assign w_unused = ^{HADDR[31:ADDR_W], HTRANS[0]};

    // Next-state decode; a new address phase is only taken while the bus is ready
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                if (r_cnt == 3'd0) w_next = S_DATA;
            end
`ifdef AHBL_REGFILE_ERR_EN
            S_ERR1: begin
                w_next = S_ERR2;
            end
`endif
            default: begin
                if (HREADY) begin
                    if (w_cap) begin
                        w_load = 1'b1;
`ifdef AHBL_REGFILE_ERR_EN
                        if (w_abad) w_next = S_ERR1;
                        else
`endif
                        w_next = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
        endcase
    end

    // State register, address-phase capture and wait-state counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_lo    <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_idx   <= w_aidx;
                r_lo    <= HADDR[1:0];
                r_size  <= HSIZE;
                r_write <= HWRITE;
                r_bad   <= w_abad;
                r_cnt   <= WS_LOAD;
            end else if (r_state == S_WAIT && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Byte-lane enables from the captured size and low address bits
    always_comb begin
        w_be = 4'b0000;
        unique case (1'b1)
            (r_size == 3'd0): w_be = 4'b0001 << r_lo;
            (r_size == 3'd1): w_be = r_lo[1] ? 4'b1100 : 4'b0011;
            (r_size == 3'd2): w_be = 4'b1111;
            default:          w_be = 4'b0000;
        endcase
    end

    // Register file write and the one-cycle strobe that follows each commit
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
            r_stb <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_stb[i] <= w_commit && (r_idx == IW'(i));
                if (w_commit && (r_idx == IW'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_be[b]) r_regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read mux: data only in the OKAY data phase of a decodable access
    always_comb begin
        HRDATA = 32'h0;
        if (r_state == S_DATA && !r_bad) begin
            if (r_idx == ID_IDX) begin
                HRDATA = ID;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (r_idx == IW'(i)) HRDATA = r_regs[i];
                end
            end
        end
    end

`ifdef AHBL_REGFILE_ERR_EN
    assign HREADYOUT = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
    assign HREADYOUT = (r_state != S_WAIT);
    assign HRESP     = 1'b0;
`endif

    assign reg_q      = r_regs;
    assign reg_wr_stb = r_stb;

endmodule

// File: doc/ahbl_regfile_slave.md
Name: ahbl_regfile_slave

Overview:
- Parametrised AHB-Lite register-file slave. Provides NUM_REGS 32-bit read/write control registers plus one read-only ID word.
- Supports byte, halfword and word writes.
- Inserts a configurable number of wait states per data phase.
- Exports every register value and a per-register one-cycle write strobe to downstream logic.

Parameters:
- ID, 32'hABCD_EF00, value returned by the read-only ID register.
- NUM_REGS, 4, number of RW registers; legal range 1..64.
- RESET_VAL, 32'h0000_0000, reset value of every RW register.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in each OKAY data phase; legal range 0..7.
- ADDR_W, 12, low HADDR bits decoded by this slave; upper bits are ignored.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ or SEQ
- HREADY  in  1  bus ready; address phase accepted when high
- HSIZE  in  3  transfer size
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data, valid in the data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- reg_q  out  NUM_REGS*32  register values; reg N occupies bits [32N+31:32N]
- reg_wr_stb  out  NUM_REGS  one-cycle pulse per register, asserted in the cycle after its write commits

Behaviour:
- Address map (word index = HADDR[ADDR_W-1:2]):
  - Index 0..NUM_REGS-1: RW registers.
  - Index NUM_REGS: ID register, read-only.
  - Any index above NUM_REGS: out of range.
- Address phase is captured only when HREADY & HSEL & HTRANS[1]. Captured fields: index, HADDR[1:0], HSIZE, HWRITE.
- Any other cycle with HREADY high returns the FSM to IDLE (IDLE/BUSY transfer, or not selected).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - On capture of a valid access, next state is WAIT if WAIT_STATES>0, else DATA.
  - WAIT holds HREADYOUT=0 for exactly WAIT_STATES cycles, using a 3-bit down-counter, then moves to DATA.
  - DATA drives HREADYOUT=1 and HRESP=0.
  - From DATA, a new address phase may be captured in the same cycle, giving back-to-back transfers.
- Write commit happens in the DATA cycle using HWDATA:
  - Byte lanes: HSIZE=0 → lane HADDR[1:0]; HSIZE=1 → lanes selected by HADDR[1] (low bit ignored); HSIZE=2 → all four lanes.
  - Non-enabled lanes keep their value.
  - reg_wr_stb[idx] pulses for one cycle after commit.
- Write to the ID register: ignored, OKAY response, no strobe.
- Read data:
  - HRDATA = selected register (or ID) during DATA; 0 in all other states.
  - A read immediately after a write to the same register returns the new value.
- Errors:
  - Out-of-range index or HSIZE>2: handled as defined under Optional Feature.
  - The ERROR path ignores WAIT_STATES.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, reg_wr_stb=0, FSM=IDLE, all registers = RESET_VAL.
- Reset asserted mid-transfer: any pending write is discarded and all outputs take reset values immediately (asynchronous).
- Synthesis: NUM_REGS+1 not a power of two is legal; unused indices are out of range.

Optional Feature:
- Macro: AHBL_REGFILE_ERR_EN.
- Defined: out-of-range or HSIZE>2 accesses produce the AHB-Lite two-cycle ERROR response.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - No register changes, no strobe, HRDATA=0.
- Undefined:
  - ERR1/ERR2 states are not built and HRESP is tied 0.
  - Such accesses complete through the normal WAIT/DATA path as OKAY.
  - Writes are ignored; reads return 0.

Test Plan:
- Reset, then read each register and ID (NUM_REGS=4, WAIT_STATES=0) → reads 0x00000000 ×4 then 0xABCDEF00; HREADYOUT=1 throughout; HRESP=0.
- Word write 0x12345678 to index 2, then byte write 0xAA at address 0x009 (HSIZE=0) → read index 2 = 0x1234AA78; reg_wr_stb[2] pulses once per write; reg_q bits [95:64] match.
- WAIT_STATES=3, back-to-back write index 1 = 0xDEADBEEF then read index 1 → each data phase has exactly 3 HREADYOUT-low cycles; read returns 0xDEADBEEF.
- With AHBL_REGFILE_ERR_EN, write to index 7 (NUM_REGS=4) → HREADYOUT/HRESP = 0/1 then 1/1; no strobe; registers unchanged. Without the macro → OKAY, write ignored, read returns 0.
- Write 0x0 to ID index 4 → OKAY; ID still reads 0xABCDEF00.
- Assert HRESETn low during a WAIT cycle of a write → HREADYOUT=1 immediately; register keeps RESET_VAL; no strobe after release.
